instr_fetch_mem: RTL and testbench

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_mem.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory with registered fetch, program loading and an end-of-program
// drain sequence that halts the fetch unit a fixed number of cycles after the marker.
module instr_fetch_mem #(
    parameter int          XLEN     = 32,
    parameter int          DEPTH    = 64,
    parameter int          DRAIN    = 6,
    parameter logic [31:0] END_WORD = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [XLEN-1:0]          pc,
    input  logic                     stall,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    output logic [31:0]              instruction,
    output logic                     inst_valid,
    output logic                     misaligned,
    output logic                     out_of_range,
    output logic                     mostrar,
    output logic                     done
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DRAIN) + 1;
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEPTH_X  = XLEN'(DEPTH);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(DRAIN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   instr_n;
    logic          valid_n, mis_n, oor_n, mostrar_n, done_n;

    logic [31:0]     mem [DEPTH];
    logic [XLEN-1:0] word_idx;
    logic [31:0]     fetch_word;
    logic            fetch_mis, fetch_oor;

    // Program storage is never reset, so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Word selection; the read is sampled by the output register, giving
    // read-before-write behaviour against a same-edge load.
    always_comb begin
        word_idx   = {2'b00, pc[XLEN-1:2]};
        fetch_word = mem[word_idx[AW-1:0]];
        fetch_mis  = 1'b0;
        fetch_oor  = 1'b0;
        if (pc[1:0] != 2'b00) begin
            fetch_word = NOP;
            fetch_mis  = 1'b1;
        end else if (word_idx >= DEPTH_X) begin
            fetch_word = END_WORD;
            fetch_oor  = 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        instr_n   = instruction;
        valid_n   = inst_valid;
        mis_n     = misaligned;
        oor_n     = out_of_range;
        mostrar_n = mostrar;
        done_n    = done;
        case (state)
            S_RUN: begin
                if (!stall) begin
                    instr_n = fetch_word;
                    valid_n = 1'b1;
                    mis_n   = fetch_mis;
                    oor_n   = fetch_oor;
                    if (fetch_word == END_WORD) begin
                        state_n = S_DRAIN;
                        cnt_n   = CNT_LOAD;
                        if (CNT_LOAD == CNT_ONE) begin
                            mostrar_n = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Counter is always >= 1 here, so the decrement cannot wrap.
                if (!stall) begin
                    cnt_n = cnt - CNT_ONE;
                    if (cnt_n == CNT_ONE) begin
                        mostrar_n = 1'b1;
                    end
                    if (cnt_n == '0) begin
                        state_n = S_HALT;
                        done_n  = 1'b1;
                        valid_n = 1'b0;
                        instr_n = NOP;
                        mis_n   = 1'b0;
                        oor_n   = 1'b0;
                    end else begin
                        instr_n = fetch_word;
                        valid_n = 1'b1;
                        mis_n   = fetch_mis;
                        oor_n   = fetch_oor;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            cnt          <= '0;
            instruction  <= NOP;
            inst_valid   <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            mostrar      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            instruction  <= instr_n;
            inst_valid   <= valid_n;
            misaligned   <= mis_n;
            out_of_range <= oor_n;
            mostrar      <= mostrar_n;
            done         <= done_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed self-checking bench for instr_fetch_mem: fetch, drain/halt timing,
// stall hold, misaligned/out-of-range selection, read-before-write and reset abort.
module tb_instr_fetch_mem;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 64;
    localparam int          DRAIN    = 6;
    localparam logic [31:0] END_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] instruction;
    logic        inst_valid, misaligned, out_of_range, mostrar, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .XLEN(XLEN), .DEPTH(DEPTH), .DRAIN(DRAIN), .END_WORD(END_WORD)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .instruction(instruction), .inst_valid(inst_valid),
        .misaligned(misaligned), .out_of_range(out_of_range),
        .mostrar(mostrar), .done(done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = 6'(idx);
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_instr"}, instruction, NOP);
        check_eq({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check_eq({tag, "_mis"}, 32'(misaligned), 32'd0);
        check_eq({tag, "_oor"}, 32'(out_of_range), 32'd0);
        check_eq({tag, "_mostrar"}, 32'(mostrar), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        pc = addr;
        step();
        check_eq({tag, "_instr"}, instruction, exp);
        check_eq({tag, "_valid"}, 32'(inst_valid), 32'd1);
    endtask

    // Entered right after the end marker has been registered (counter = DRAIN-1).
    // Fetches continue from word 3; stall is held for sl cycles after the next edge.
    task automatic run_drain(input int sl, input string tag);
        logic [31:0] exp_i;
        logic        exp_v;
        int          widx;
        bit          stalled;
        widx  = 3;
        pc    = 32'd12;
        stall = 1'b0;
        exp_i = '0;
        exp_v = 1'b1;
        for (int n = 2; n <= 6 + sl; n++) begin
            step();
            stalled = (n >= 3) && (n <= 2 + sl);
            if (!stalled) begin
                if (n == 6 + sl) begin
                    exp_i = NOP;
                    exp_v = 1'b0;
                end else begin
                    exp_i = 32'h1000_0000 + 32'(widx);
                    widx++;
                end
            end
            check_eq($sformatf("%s_instr_n%0d", tag, n), instruction, exp_i);
            check_eq($sformatf("%s_valid_n%0d", tag, n), 32'(inst_valid), 32'(exp_v));
            check_eq($sformatf("%s_mostrar_n%0d", tag, n), 32'(mostrar), 32'(n >= 5 + sl));
            check_eq($sformatf("%s_done_n%0d", tag, n), 32'(done), 32'(n >= 6 + sl));
            stall = (n >= 2) && (n < 2 + sl);
            pc    = 32'(4 * widx);
        end
        pc    = 32'd0;
        step();
        check_eq({tag, "_halt_instr"}, instruction, NOP);
        check_eq({tag, "_halt_valid"}, 32'(inst_valid), 32'd0);
        check_eq({tag, "_halt_mostrar"}, 32'(mostrar), 32'd1);
        check_eq({tag, "_halt_done"}, 32'(done), 32'd1);
    endtask

    task automatic release_rst();
        step();
        rst   = 1'b0;
        pc    = 32'd0;
        stall = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        pc      = 32'd0;
        stall   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        #2;
        check_reset("por");

        load(0, 32'h0050_0093);
        load(1, 32'h00A0_0113);
        load(2, 32'h0000_0000);
        for (int i = 3; i < 16; i++) begin
            load(i, 32'h1000_0000 + 32'(i));
        end
        check_reset("por_loaded");

        // Basic program run to halt
        rst = 1'b0;
        fetch_chk("f0", 32'd0, 32'h0050_0093);
        check_eq("f0_mis", 32'(misaligned), 32'd0);
        fetch_chk("f4", 32'd4, 32'h00A0_0113);
        fetch_chk("f8_marker", 32'd8, 32'h0000_0000);
        check_eq("f8_mostrar", 32'(mostrar), 32'd0);
        run_drain(0, "drain");

        // Reset in HALT, then rerun with a 3-cycle stall during DRAIN
        rst = 1'b1;
        #1;
        check_reset("rst_halt");
        release_rst();
        fetch_chk("s0", 32'd0, 32'h0050_0093);
        fetch_chk("s4", 32'd4, 32'h00A0_0113);
        fetch_chk("s8", 32'd8, 32'h0000_0000);
        run_drain(3, "stall");

        // Reset mid-DRAIN with counter at 3
        rst = 1'b1;
        #1;
        release_rst();
        fetch_chk("m0", 32'd0, 32'h0050_0093);
        fetch_chk("m4", 32'd4, 32'h00A0_0113);
        fetch_chk("m8", 32'd8, 32'h0000_0000);
        fetch_chk("m12", 32'd12, 32'h1000_0003);
        pc = 32'd16;
        step();
        rst = 1'b1;
        #1;
        check_reset("rst_drain");
        release_rst();
        fetch_chk("after_rst_f0", 32'd0, 32'h0050_0093);

        // Same-edge load and fetch returns the old word
        pc      = 32'd4;
        ld_en   = 1'b1;
        ld_addr = 6'd1;
        ld_data = 32'hDEAD_BEEF;
        step();
        ld_en   = 1'b0;
        check_eq("rbw_old", instruction, 32'h00A0_0113);
        fetch_chk("rbw_new", 32'd4, 32'hDEAD_BEEF);

        // Misaligned and out-of-range selection
        fetch_chk("misal", 32'h0000_0102, NOP);
        check_eq("misal_flag", 32'(misaligned), 32'd1);
        check_eq("misal_oor", 32'(out_of_range), 32'd0);
        check_eq("misal_done", 32'(done), 32'd0);
        fetch_chk("oor", 32'(4 * DEPTH), END_WORD);
        check_eq("oor_flag", 32'(out_of_range), 32'd1);
        check_eq("oor_mis", 32'(misaligned), 32'd0);
        run_drain(0, "oor_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
